// File: rtl/lii_rx_unpack.sv
// rtl/lii_rx_unpack.sv - LII phy beat filter, word reassembly and 2-deep kernel input buffer
module lii_rx_unpack #(
    parameter int         PW       = 128,
    parameter int         LW       = 72,
    parameter logic [7:0] LOCAL_ID = 8'd0
) (
    input  logic          aclk,
    input  logic          arstn,
    input  logic [PW-1:0] lii_in_p0_tdata,
    input  logic          lii_in_p0_tvalid,
    output logic          lii_in_p0_tready,
    input  logic [7:0]    lii_in_p0_src,
    input  logic [7:0]    lii_in_p0_dst,
    output logic [LW-1:0] kin_stream_tdata,
    output logic          kin_stream_tvalid,
    input  logic          kin_stream_tready,
    output logic [15:0]   drop_count,
    output logic          src_err,
    output logic          ce
);

    localparam int NB = (LW + PW - 1) / PW;
    localparam int CW = ($clog2(NB) > 2) ? $clog2(NB) : 2;
    localparam int AW = NB * PW;
    localparam logic [CW-1:0] LAST = CW'(NB - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    src_q, src_d;
    logic [AW-1:0] asm_q, asm_d;
    logic [15:0]   drop_q, drop_d;
    logic          err_q, err_d;
    logic [LW-1:0] ent0_q, ent0_d, ent1_q, ent1_d;
    logic [1:0]    fcnt_q, fcnt_d;

    logic          beat_acc;
    logic          push;
    logic          pop;
    logic [CW-1:0] slot;

    // The final beat of a word needs a free FIFO slot; earlier beats only fill the assembly register.
    assign lii_in_p0_tready = arstn & ((cnt_q != LAST) | (fcnt_q != 2'd2));
    assign beat_acc         = lii_in_p0_tvalid & lii_in_p0_tready;
    assign pop              = (fcnt_q != 2'd0) & kin_stream_tready;

    assign kin_stream_tdata  = ent0_q;
    assign kin_stream_tvalid = (fcnt_q != 2'd0);
    assign ce                = (fcnt_q != 2'd0);
    assign drop_count        = drop_q;
    assign src_err           = err_q;

    // Beat filtering, src lock and placement of each beat into the assembly register.
    always_comb begin
        cnt_d  = cnt_q;
        src_d  = src_q;
        asm_d  = asm_q;
        drop_d = drop_q;
        err_d  = err_q;
        push   = 1'b0;
        slot   = cnt_q;
        if (beat_acc) begin
            if (lii_in_p0_dst != LOCAL_ID) begin
                if (drop_q != 16'hFFFF) begin
                    drop_d = drop_q + 16'd1;
                end
            end else begin
                // A src change mid-word abandons the partial word and restarts with this beat.
                if ((cnt_q != '0) && (lii_in_p0_src != src_q)) begin
                    err_d = 1'b1;
                    slot  = '0;
                end
                if (slot == '0) begin
                    src_d = lii_in_p0_src;
                end
                for (int k = 0; k < NB; k++) begin
                    if (CW'(k) == slot) begin
                        asm_d[k*PW +: PW] = lii_in_p0_tdata;
                    end
                end
                if (slot == LAST) begin
                    push  = 1'b1;
                    cnt_d = '0;
                end else begin
                    cnt_d = slot + CW'(1);
                end
            end
        end
    end

    // Two-entry output FIFO; entry 0 is always the head presented to the kernel.
    always_comb begin
        ent0_d = ent0_q;
        ent1_d = ent1_q;
        fcnt_d = fcnt_q;
        case ({push, pop})
            2'b10: begin
                if (fcnt_q == 2'd0) begin
                    ent0_d = asm_d[LW-1:0];
                end else begin
                    ent1_d = asm_d[LW-1:0];
                end
                fcnt_d = fcnt_q + 2'd1;
            end
            2'b01: begin
                ent0_d = ent1_q;
                fcnt_d = fcnt_q - 2'd1;
            end
            2'b11: begin
                // Push needs count<2 and pop needs count>0, so exactly one word is resident.
                ent0_d = asm_d[LW-1:0];
            end
            default: begin
            end
        endcase
    end

    // State registers; reset discards any partial and buffered words.
    always_ff @(posedge aclk) begin
        if (!arstn) begin
            cnt_q  <= '0;
            src_q  <= '0;
            asm_q  <= '0;
            drop_q <= '0;
            err_q  <= 1'b0;
            ent0_q <= '0;
            ent1_q <= '0;
            fcnt_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            src_q  <= src_d;
            asm_q  <= asm_d;
            drop_q <= drop_d;
            err_q  <= err_d;
            ent0_q <= ent0_d;
            ent1_q <= ent1_d;
            fcnt_q <= fcnt_d;
        end
    end

endmodule

// File: tb/tb_lii_rx_unpack.sv
// tb/tb_lii_rx_unpack.sv - scoreboard bench for lii_rx_unpack with a queue-based reference model
module tb_lii_rx_unpack;

    localparam int         PW  = 128;
    localparam int         LW  = 200;
    localparam logic [7:0] LID = 8'h3C;
    localparam int         NB  = (LW + PW - 1) / PW;

    logic          aclk = 1'b0;
    logic          arstn = 1'b0;
    logic [PW-1:0] lii_in_p0_tdata = '0;
    logic          lii_in_p0_tvalid = 1'b0;
    logic          lii_in_p0_tready;
    logic [7:0]    lii_in_p0_src = '0;
    logic [7:0]    lii_in_p0_dst = '0;
    logic [LW-1:0] kin_stream_tdata;
    logic          kin_stream_tvalid;
    logic          kin_stream_tready = 1'b0;
    logic [15:0]   drop_count;
    logic          src_err;
    logic          ce;

    lii_rx_unpack #(.PW(PW), .LW(LW), .LOCAL_ID(LID)) dut (
        .aclk              (aclk),
        .arstn             (arstn),
        .lii_in_p0_tdata   (lii_in_p0_tdata),
        .lii_in_p0_tvalid  (lii_in_p0_tvalid),
        .lii_in_p0_tready  (lii_in_p0_tready),
        .lii_in_p0_src     (lii_in_p0_src),
        .lii_in_p0_dst     (lii_in_p0_dst),
        .kin_stream_tdata  (kin_stream_tdata),
        .kin_stream_tvalid (kin_stream_tvalid),
        .kin_stream_tready (kin_stream_tready),
        .drop_count        (drop_count),
        .src_err           (src_err),
        .ce                (ce)
    );

    always #5 aclk = ~aclk;

    // Reference model state: partial word as a list of beats, buffered words as a count.
    logic [PW-1:0] part[$];
    logic [7:0]    part_src;
    int            m_occ;
    int            m_drop;
    bit            m_err;
    logic [LW-1:0] exp_q[$];
    logic [LW-1:0] e_w;
    int            n_cmp = 0;
    int            n_fail = 0;
    bit            dummy;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [PW-1:0] rnd_beat();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // One clock: check observable state, drive inputs, advance the model across the next edge.
    task automatic cycle(input bit v, input logic [7:0] d, input logic [7:0] s,
                         input logic [PW-1:0] data, input bit ktr, output bit acc);
        bit exp_tr;
        bit pop;
        bit push;
        logic [NB*PW-1:0] w;
        @(negedge aclk);
        exp_tr = !((part.size() == NB - 1) && (m_occ >= 2));
        chk("tready", lii_in_p0_tready, exp_tr);
        chk("tvalid", kin_stream_tvalid, m_occ != 0);
        chk("ce", ce, m_occ != 0);
        chk("drop_count", drop_count, m_drop);
        chk("src_err", src_err, m_err);
        lii_in_p0_tvalid  = v;
        lii_in_p0_dst     = d;
        lii_in_p0_src     = s;
        lii_in_p0_tdata   = data;
        kin_stream_tready = ktr;
        pop  = (m_occ != 0) && ktr;
        push = 1'b0;
        acc  = v && exp_tr;
        if (acc) begin
            if (d != LID) begin
                if (m_drop < 65535) m_drop++;
            end else begin
                if (part.size() > 0 && s != part_src) begin
                    m_err = 1'b1;
                    part.delete();
                end
                if (part.size() == 0) part_src = s;
                part.push_back(data);
                if (part.size() == NB) begin
                    w = '0;
                    for (int i = 0; i < NB; i++) w[i*PW +: PW] = part[i];
                    exp_q.push_back(w[LW-1:0]);
                    part.delete();
                    push = 1'b1;
                end
            end
        end
        m_occ = m_occ - int'(pop) + int'(push);
    endtask

    task automatic send(input logic [7:0] d, input logic [7:0] s, input logic [PW-1:0] data, input bit ktr);
        bit acc;
        for (int i = 0; i < 40; i++) begin
            cycle(1'b1, d, s, data, ktr, acc);
            if (acc) return;
        end
        n_cmp++;
        n_fail++;
        $display("FAIL send_timeout: beat not accepted within 40 cycles, required acceptance");
    endtask

    task automatic do_reset(input int n);
        @(negedge aclk);
        arstn = 1'b0;
        lii_in_p0_tvalid = 1'b0;
        part.delete();
        exp_q.delete();
        m_occ  = 0;
        m_drop = 0;
        m_err  = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge aclk);
            chk("rst_tready", lii_in_p0_tready, 0);
            chk("rst_tvalid", kin_stream_tvalid, 0);
            chk("rst_tdata", kin_stream_tdata, 0);
            chk("rst_drop", drop_count, 0);
            chk("rst_src_err", src_err, 0);
            chk("rst_ce", ce, 0);
        end
        arstn = 1'b1;
    endtask

    // Monitor: every kernel-side handshake pops the oldest expected word.
    initial begin
        forever begin
            @(negedge aclk);
            #1;
            if (arstn && kin_stream_tvalid && kin_stream_tready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_word: got %0h expected no word", kin_stream_tdata);
                end else begin
                    e_w = exp_q.pop_front();
                    chk("word", kin_stream_tdata, e_w);
                end
            end
        end
    end

    initial begin
        logic [7:0] cur_src;
        do_reset(3);

        // Single two-beat word, kernel always ready.
        send(LID, 8'h01, {32{4'h1}}, 1'b1);
        send(LID, 8'h01, {32{4'h2}}, 1'b1);
        repeat (3) cycle(1'b0, LID, 8'h01, '0, 1'b1, dummy);

        // Back-pressure: two words fill the FIFO, the third final beat stalls.
        for (int w = 0; w < 2; w++) begin
            send(LID, 8'h07, rnd_beat(), 1'b0);
            send(LID, 8'h07, rnd_beat(), 1'b0);
        end
        send(LID, 8'h07, rnd_beat(), 1'b0);
        repeat (3) cycle(1'b1, LID, 8'h07, {32{4'hC}}, 1'b0, dummy);
        send(LID, 8'h07, {32{4'hC}}, 1'b1);
        repeat (5) cycle(1'b0, LID, 8'h07, '0, 1'b1, dummy);

        // Dst filter: five foreign beats interleaved with one local word.
        for (int i = 0; i < 5; i++) begin
            send(8'h03, 8'h02, rnd_beat(), 1'b1);
            if (i == 1 || i == 3) send(LID, 8'h02, rnd_beat(), 1'b1);
        end
        repeat (3) cycle(1'b0, LID, 8'h02, '0, 1'b1, dummy);

        // Src change mid-word: partial word dropped, second beat restarts a word.
        send(LID, 8'h01, {32{4'hA}}, 1'b1);
        send(LID, 8'h02, {32{4'hB}}, 1'b1);
        send(LID, 8'h02, {32{4'hD}}, 1'b1);
        repeat (3) cycle(1'b0, LID, 8'h02, '0, 1'b1, dummy);

        // Reset with one word buffered and a partial word in assembly.
        send(LID, 8'h04, rnd_beat(), 1'b0);
        send(LID, 8'h04, rnd_beat(), 1'b0);
        send(LID, 8'h04, rnd_beat(), 1'b0);
        do_reset(2);
        send(LID, 8'h05, {32{4'h6}}, 1'b1);
        send(LID, 8'h05, {32{4'h9}}, 1'b1);
        repeat (3) cycle(1'b0, LID, 8'h05, '0, 1'b1, dummy);

        // Randomized traffic.
        cur_src = 8'h11;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 31) == 0) cur_src = 8'($urandom);
            cycle($urandom_range(0, 3) != 0,
                  ($urandom_range(0, 4) == 0) ? 8'($urandom_range(0, 255)) : LID,
                  cur_src, rnd_beat(), $urandom_range(0, 2) != 0, dummy);
        end

        // Drive drop_count into saturation.
        for (int i = 0; i < 65540; i++) begin
            cycle(1'b1, 8'h00, 8'h11, '0, 1'b1, dummy);
        end
        cycle(1'b0, LID, 8'h11, '0, 1'b1, dummy);
        chk("drop_saturated", drop_count, 16'hFFFF);

        // Drain remaining words.
        for (int i = 0; i < 20 && m_occ != 0; i++) cycle(1'b0, LID, 8'h11, '0, 1'b1, dummy);
        @(negedge aclk);
        #2;
        chk("drain_occ", m_occ, 0);
        chk("drain_queue", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
